// File: rtl/vram_mp.sv
// -----------------------------------------------------------------------------
// vram_mp : multi-port video frame-buffer RAM with a built-in fill engine.
//
// Holds DEPTH = 2**ADDR_W words of DATA_W bits. One host write port with byte
// enables and a valid/ready handshake. N_RD fully independent read ports with
// one cycle of latency. A fill engine writes one word per cycle across a
// contiguous, wrapping address range to clear or paint a region.
//
// Build option:
//   VRAM_MP_RD_BYPASS_EN  defined   -> a read hitting the word written in the
//                                      same cycle returns the merged new word
//                                      (write-first).
//                         undefined -> the same read returns the old word
//                                      (read-first, plain block RAM mapping).
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset (memory contents are kept)
//   ra / rd     packed read addresses / registered read data, port i at
//               [i*ADDR_W +: ADDR_W] / [i*DATA_W +: DATA_W]
//   wa, wd, wbe host write address, data and byte enables
//   wvalid      host write request; wready high means accepted this cycle
//   fill_start  one-cycle pulse starting a fill (ignored unless idle)
//   fill_base   first fill address, fill_len word count (saturated to DEPTH),
//   fill_value  fill word; all three sampled with fill_start
//   fill_busy   fill in progress
//   fill_done   one-cycle pulse when a fill completes
// -----------------------------------------------------------------------------
module vram_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 19,
    parameter int N_RD   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_RD*ADDR_W-1:0] ra,
    output logic [N_RD*DATA_W-1:0] rd,
    input  logic [ADDR_W-1:0]      wa,
    input  logic [DATA_W-1:0]      wd,
    input  logic [DATA_W/8-1:0]    wbe,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic                   fill_start,
    input  logic [ADDR_W-1:0]      fill_base,
    input  logic [ADDR_W:0]        fill_len,
    input  logic [DATA_W-1:0]      fill_value,
    output logic                   fill_busy,
    output logic                   fill_done
);

    localparam int N_BYTES = DATA_W / 8;
    localparam int DEPTH   = 2 ** ADDR_W;

    // Length constants in the (ADDR_W+1)-bit count domain.
    localparam logic [ADDR_W:0] LEN_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LEN_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

`ifdef VRAM_MP_RD_BYPASS_EN
    // Replace the enabled bytes of old_word with those of new_word.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0]  old_word,
        input logic [DATA_W-1:0]  new_word,
        input logic [N_BYTES-1:0] be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < N_BYTES; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction
`endif

    // Storage: deliberately no reset so it maps onto block RAM.
    logic [DATA_W-1:0] mem_r [DEPTH];

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   fill_addr_r;
    logic [ADDR_W:0]     fill_cnt_r;
    logic [DATA_W-1:0]   fill_val_r;
    logic [ADDR_W:0]     len_sat_s;

    logic                wready_s;
    logic                fill_busy_s;
    logic                fill_done_s;

    logic                wen_s;
    logic [ADDR_W-1:0]   waddr_s;
    logic [DATA_W-1:0]   wdata_s;
    logic [N_BYTES-1:0]  wbe_s;

    logic [ADDR_W-1:0]   rd_addr_s [N_RD];
    logic [DATA_W-1:0]   rdata_s   [N_RD];
    logic [N_RD*DATA_W-1:0] rd_r;

    // Requested length clamped to the memory size.
    always_comb begin
        if (fill_len > LEN_DEPTH) begin
            len_sat_s = LEN_DEPTH;
        end else begin
            len_sat_s = fill_len;
        end
    end

    // Fill FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fill FSM next-state logic; a start outside IDLE is simply not looked at.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fill_start) begin
                    if (fill_len == LEN_ZERO) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (fill_cnt_r == LEN_ONE) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Fill FSM outputs decoded from the state register.
    always_comb begin
        wready_s    = 1'b0;
        fill_busy_s = 1'b0;
        fill_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wready_s = 1'b1;
            end
            ST_FILL: begin
                fill_busy_s = 1'b1;
            end
            ST_DONE: begin
                fill_done_s = 1'b1;
            end
            default: begin
                wready_s = 1'b0;
            end
        endcase
    end

    assign wready    = wready_s;
    assign fill_busy = fill_busy_s;
    assign fill_done = fill_done_s;

    // Fill datapath: capture the job on start, then walk address and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_addr_r <= {ADDR_W{1'b0}};
            fill_cnt_r  <= LEN_ZERO;
            fill_val_r  <= {DATA_W{1'b0}};
        end else if ((state_r == ST_IDLE) && fill_start) begin
            fill_addr_r <= fill_base;
            fill_cnt_r  <= len_sat_s;
            fill_val_r  <= fill_value;
        end else if (state_r == ST_FILL) begin
            // Natural ADDR_W-bit overflow gives the modulo-DEPTH wrap.
            fill_addr_r <= fill_addr_r + ADDR_ONE;
            fill_cnt_r  <= fill_cnt_r - LEN_ONE;
        end else begin
            fill_addr_r <= fill_addr_r;
            fill_cnt_r  <= fill_cnt_r;
            fill_val_r  <= fill_val_r;
        end
    end

    // Single physical write port: the fill owns it while filling, the host
    // only while idle, so the two can never collide. Reset blocks all writes,
    // which is what aborts a fill immediately.
    always_comb begin
        wen_s   = 1'b0;
        waddr_s = wa;
        wdata_s = wd;
        wbe_s   = wbe;
        if (rst) begin
            wen_s = 1'b0;
        end else if (state_r == ST_FILL) begin
            wen_s   = 1'b1;
            waddr_s = fill_addr_r;
            wdata_s = fill_val_r;
            wbe_s   = {N_BYTES{1'b1}};
        end else if (wvalid && wready_s) begin
            wen_s = 1'b1;
        end else begin
            wen_s = 1'b0;
        end
    end

    // Byte-masked memory write.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_BYTES; k++) begin
            if (wen_s && wbe_s[k]) begin
                mem_r[waddr_s][8*k +: 8] <= wdata_s[8*k +: 8];
            end
        end
    end

    // Per-port read data selection, including same-cycle write forwarding
    // when the bypass build is selected.
    always_comb begin
        for (int i = 0; i < N_RD; i++) begin
            rd_addr_s[i] = ra[i*ADDR_W +: ADDR_W];
`ifdef VRAM_MP_RD_BYPASS_EN
            if (wen_s && (rd_addr_s[i] == waddr_s)) begin
                rdata_s[i] = merge_bytes(mem_r[rd_addr_s[i]], wdata_s, wbe_s);
            end else begin
                rdata_s[i] = mem_r[rd_addr_s[i]];
            end
`else
            rdata_s[i] = mem_r[rd_addr_s[i]];
`endif
        end
    end

    // Registered read data, forced to zero while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_r <= {(N_RD*DATA_W){1'b0}};
        end else begin
            for (int i = 0; i < N_RD; i++) begin
                rd_r[i*DATA_W +: DATA_W] <= rdata_s[i];
            end
        end
    end

    assign rd = rd_r;

endmodule

// File: tb/tb_vram_mp.sv
// -----------------------------------------------------------------------------
// Self-checking bench for vram_mp (default parameters: 32-bit words, 19-bit
// addresses, two read ports). Directed vector table for byte-enable writes,
// hand-written sequences for the fill engine corner cases, and a randomized
// phase compared against a word-level memory model held in an associative
// array.
// -----------------------------------------------------------------------------
module tb_vram_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 19;
    localparam int N_RD   = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_RD*ADDR_W-1:0] ra;
    logic [N_RD*DATA_W-1:0] rd;
    logic [ADDR_W-1:0]      wa;
    logic [DATA_W-1:0]      wd;
    logic [DATA_W/8-1:0]    wbe;
    logic                   wvalid;
    logic                   wready;
    logic                   fill_start;
    logic [ADDR_W-1:0]      fill_base;
    logic [ADDR_W:0]        fill_len;
    logic [DATA_W-1:0]      fill_value;
    logic                   fill_busy;
    logic                   fill_done;

    always #5 clk = ~clk;

    vram_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RD(N_RD)) dut (
        .clk        (clk),
        .rst        (rst),
        .ra         (ra),
        .rd         (rd),
        .wa         (wa),
        .wd         (wd),
        .wbe        (wbe),
        .wvalid     (wvalid),
        .wready     (wready),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference memory: word address -> word, only for addresses written.
    logic [31:0] model_mem [int];

    typedef struct {
        logic [18:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } wr_vec_t;

    wr_vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) m = m | (32'hFF << (8 * k));
        end
        return m;
    endfunction

    task automatic model_write(input int addr, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] old;
        logic [31:0] m;
        old = model_mem.exists(addr) ? model_mem[addr] : 32'h0;
        m = byte_mask(be);
        model_mem[addr] = (old & ~m) | (data & m);
    endtask

    task automatic host_write(input logic [18:0] addr, input logic [31:0] data, input logic [3:0] be);
        wa = addr;
        wd = data;
        wbe = be;
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        model_write(int'(addr), data, be);
    endtask

    task automatic read_both(input logic [18:0] addr, input logic [31:0] exp, input string name);
        ra = {addr, addr};
        step();
        check({name, "_p0"}, rd[31:0], exp);
        check({name, "_p1"}, rd[63:32], exp);
    endtask

    task automatic start_fill(input logic [18:0] base, input logic [19:0] len, input logic [31:0] val);
        fill_base = base;
        fill_len = len;
        fill_value = val;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
    endtask

    // Watch a fixed window of cycles; bounded by construction.
    task automatic monitor(input int ncyc, output int busy_n, output int done_n, output int wr_bad);
        busy_n = 0;
        done_n = 0;
        wr_bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (fill_busy === 1'b1) busy_n++;
            if (fill_done === 1'b1) done_n++;
            if ((fill_busy === 1'b1) && (wready !== 1'b0)) wr_bad++;
            step();
        end
    endtask

    initial begin
        int busy_n, done_n, wr_bad;
        logic [18:0] r0, r1, w, base;
        logic [31:0] d, e0, e1, e0_old, e1_old, val;
        logic [3:0]  b;
        logic        v;
        int          len;

        rst = 1'b1;
        ra = {19'h20, 19'h10};
        wa = 19'h0;
        wd = 32'h0;
        wbe = 4'h0;
        wvalid = 1'b0;
        fill_start = 1'b0;
        fill_base = 19'h0;
        fill_len = 20'h0;
        fill_value = 32'h0;

        // Reset state.
        step();
        step();
        check("rst_rd0", rd[31:0], 32'h0);
        check("rst_rd1", rd[63:32], 32'h0);
        check("rst_wready", 32'(wready), 32'h1);
        check("rst_busy", 32'(fill_busy), 32'h0);
        check("rst_done", 32'(fill_done), 32'h0);
        rst = 1'b0;
        step();

        // Directed byte-enable vectors: each write followed by a read-back.
        vecs[0] = '{19'h100, 32'hAABBCCDD, 4'hF,    32'hAABBCCDD};
        vecs[1] = '{19'h100, 32'h11223344, 4'b0101, 32'hAA22CC44};
        vecs[2] = '{19'h101, 32'h12345678, 4'hF,    32'h12345678};
        vecs[3] = '{19'h101, 32'hFFFFFFFF, 4'b1000, 32'hFF345678};
        vecs[4] = '{19'h101, 32'h00000000, 4'b0110, 32'hFF000078};
        vecs[5] = '{19'h102, 32'hCAFEF00D, 4'hF,    32'hCAFEF00D};
        vecs[6] = '{19'h102, 32'h00000000, 4'h0,    32'hCAFEF00D};
        vecs[7] = '{19'h102, 32'h99887766, 4'b0010, 32'hCAFE770D};
        for (int i = 0; i < 8; i++) begin
            host_write(vecs[i].addr, vecs[i].data, vecs[i].be);
            read_both(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Fill with address wrap.
        host_write(19'h7FFFD, 32'h2468ACE0, 4'hF);
        host_write(19'h00002, 32'h13579BDF, 4'hF);
        start_fill(19'h7FFFE, 20'd4, 32'hDEADBEEF);
        check("wrap_wready_low", 32'(wready), 32'h0);
        monitor(12, busy_n, done_n, wr_bad);
        check("wrap_busy_cycles", 32'(busy_n), 32'd4);
        check("wrap_done_pulses", 32'(done_n), 32'd1);
        check("wrap_wready_busy", 32'(wr_bad), 32'd0);
        check("wrap_wready_after", 32'(wready), 32'h1);
        read_both(19'h7FFFE, 32'hDEADBEEF, "wrap_7fffe");
        read_both(19'h7FFFF, 32'hDEADBEEF, "wrap_7ffff");
        read_both(19'h00000, 32'hDEADBEEF, "wrap_00000");
        read_both(19'h00001, 32'hDEADBEEF, "wrap_00001");
        read_both(19'h00002, 32'h13579BDF, "wrap_00002");
        read_both(19'h7FFFD, 32'h2468ACE0, "wrap_7fffd");

        // Zero-length fill: done next cycle, nothing written, never busy.
        host_write(19'h400, 32'h0BADF00D, 4'hF);
        start_fill(19'h400, 20'd0, 32'hFFFFFFFF);
        check("zero_done", 32'(fill_done), 32'h1);
        check("zero_busy", 32'(fill_busy), 32'h0);
        step();
        check("zero_done_clear", 32'(fill_done), 32'h0);
        check("zero_wready", 32'(wready), 32'h1);
        read_both(19'h400, 32'h0BADF00D, "zero_nowrite");

        // Second start during a running fill is ignored.
        host_write(19'h600, 32'h66666666, 4'hF);
        host_write(19'h508, 32'h50850850, 4'hF);
        start_fill(19'h500, 20'd8, 32'h55AA55AA);
        busy_n = 0;
        done_n = 0;
        for (int c = 0; c < 16; c++) begin
            if (fill_busy === 1'b1) busy_n++;
            if (fill_done === 1'b1) done_n++;
            fill_start = (c == 2);
            fill_base = 19'h600;
            fill_len = 20'd3;
            fill_value = 32'h00000001;
            step();
        end
        fill_start = 1'b0;
        check("ign_busy_cycles", 32'(busy_n), 32'd8);
        check("ign_done_pulses", 32'(done_n), 32'd1);
        read_both(19'h500, 32'h55AA55AA, "ign_500");
        read_both(19'h507, 32'h55AA55AA, "ign_507");
        read_both(19'h508, 32'h50850850, "ign_508");
        read_both(19'h600, 32'h66666666, "ign_600");

        // Reset in the middle of a fill.
        for (int i = 0; i < 8; i++) host_write(19'h200 + 19'(i), 32'hA0000000 + i, 4'hF);
        start_fill(19'h200, 20'd16, 32'hF111F111);
        for (int c = 0; c < 5; c++) step();
        check("rstmid_busy_before", 32'(fill_busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_busy", 32'(fill_busy), 32'h0);
        check("rstmid_done", 32'(fill_done), 32'h0);
        check("rstmid_wready", 32'(wready), 32'h1);
        monitor(6, busy_n, done_n, wr_bad);
        check("rstmid_no_done", 32'(done_n), 32'd0);
        check("rstmid_no_busy", 32'(busy_n), 32'd0);
        for (int i = 0; i < 5; i++) read_both(19'h200 + 19'(i), 32'hF111F111, $sformatf("rstmid_fill%0d", i));
        read_both(19'h205, 32'hA0000005, "rstmid_205");
        read_both(19'h206, 32'hA0000006, "rstmid_206");

        // Read during write to the same address.
        host_write(19'h40, 32'h00000000, 4'hF);
        host_write(19'h41, 32'h41414141, 4'hF);
        ra = {19'h41, 19'h40};
        wa = 19'h40;
        wd = 32'hFFFFFFFF;
        wbe = 4'b0011;
        wvalid = 1'b1;
        step();
        wvalid = 1'b0;
`ifdef VRAM_MP_RD_BYPASS_EN
        check("rdw_same", rd[31:0], 32'h0000FFFF);
`else
        check("rdw_same", rd[31:0], 32'h00000000);
`endif
        check("rdw_other", rd[63:32], 32'h41414141);
        step();
        check("rdw_after", rd[31:0], 32'h0000FFFF);
        model_write(32'h40, 32'hFFFFFFFF, 4'b0011);

        // Host write and fill_start together in IDLE.
        host_write(19'h712, 32'h71271271, 4'hF);
        wa = 19'h700;
        wd = 32'h77007700;
        wbe = 4'hF;
        wvalid = 1'b1;
        fill_base = 19'h710;
        fill_len = 20'd2;
        fill_value = 32'h71717171;
        fill_start = 1'b1;
        check("both_wready", 32'(wready), 32'h1);
        step();
        wvalid = 1'b0;
        fill_start = 1'b0;
        check("both_busy", 32'(fill_busy), 32'h1);
        check("both_wready_low", 32'(wready), 32'h0);
        monitor(6, busy_n, done_n, wr_bad);
        check("both_busy_cycles", 32'(busy_n), 32'd2);
        check("both_done_pulses", 32'(done_n), 32'd1);
        read_both(19'h700, 32'h77007700, "both_host");
        read_both(19'h710, 32'h71717171, "both_f0");
        read_both(19'h711, 32'h71717171, "both_f1");
        read_both(19'h712, 32'h71271271, "both_f2");

        // Randomized host traffic against the reference model.
        for (int a = 0; a < 64; a++) host_write(19'h300 + 19'(a), $urandom, 4'hF);
        for (int n = 0; n < 400; n++) begin
            r0 = 19'h300 + 19'($urandom_range(0, 63));
            r1 = 19'h300 + 19'($urandom_range(0, 63));
            w = ($urandom_range(0, 2) == 0) ? r0 : 19'h300 + 19'($urandom_range(0, 63));
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            v = ($urandom_range(0, 3) != 0);
            e0_old = model_mem[int'(r0)];
            e1_old = model_mem[int'(r1)];
            if (v) model_write(int'(w), d, b);
`ifdef VRAM_MP_RD_BYPASS_EN
            e0 = model_mem[int'(r0)];
            e1 = model_mem[int'(r1)];
`else
            e0 = e0_old;
            e1 = e1_old;
`endif
            ra = {r1, r0};
            wa = w;
            wd = d;
            wbe = b;
            wvalid = v;
            step();
            check("rand_rd0", rd[31:0], e0);
            check("rand_rd1", rd[63:32], e1);
        end
        wvalid = 1'b0;

        // Randomized fills inside the window, then a full read-back sweep.
        for (int f = 0; f < 4; f++) begin
            base = 19'h300 + 19'($urandom_range(0, 50));
            len = $urandom_range(0, 12);
            val = $urandom;
            start_fill(base, 20'(len), val);
            monitor(len + 4, busy_n, done_n, wr_bad);
            check("rfill_busy", 32'(busy_n), 32'(len));
            check("rfill_done", 32'(done_n), 32'd1);
            check("rfill_wready", 32'(wr_bad), 32'd0);
            for (int j = 0; j < len; j++) model_mem[int'(base) + j] = val;
            for (int a = 0; a < 64; a++) begin
                read_both(19'h300 + 19'(a), model_mem[32'h300 + a], "rfill_sweep");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
